// File: rtl/bin2bcd_pkg.sv
// Purpose: shared constants and state encoding for the sequential binary-to-BCD converter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_e            FSM encoding IDLE/OP/DONE
//   NUM_DIGITS/DIGIT_W output digit count and digit width
//   ADJ_THRESH/ADJ_ADD double-dabble correction constants
//   WIDTH_MIN/WIDTH_MAX legal binary input widths (2^13-1 = 8191 still fits four digits)
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OP   = 2'b01,
      DONE = 2'b10
   } state_e;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;

   localparam logic [DIGIT_W-1:0] ADJ_THRESH = 4'd5;
   localparam logic [DIGIT_W-1:0] ADJ_ADD    = 4'd3;

   localparam int WIDTH_MIN = 1;
   localparam int WIDTH_MAX = 13;

endpackage : bin2bcd_pkg

// File: rtl/bcd_digit_adj.sv
// Purpose: double-dabble digit correction, "if digit >= 5 then add 3" on one BCD digit.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   digit_in   working BCD digit before the shift
//   digit_out  corrected digit; 4-bit add, carry out deliberately dropped
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   // A digit of 5..9 becomes 8..12, so its doubled value carries correctly
   // into the next decade after the shift. Values above 9 never occur in a
   // legal working register, so dropping the carry is safe.
   always_comb begin
      digit_out = digit_in;
      if (digit_in >= ADJ_THRESH) begin
         digit_out = digit_in + ADJ_ADD;
      end
   end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// Purpose: sequential double-dabble converter, WIDTH-bit unsigned binary to four BCD digits.
// Latency: start accepted at edge E0, done_tick high in the cycle after edge E(WIDTH); WIDTH+2 clocks per conversion.
// Backpressure: start is only honoured while ready=1; requests during OP/DONE are dropped, not queued.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   start      conversion request, sampled only in IDLE
//   bin        binary value, captured only on the accepted start edge
//   ready      high while idle (decoded from state)
//   done_tick  single-cycle pulse in the cycle after the result is committed
//   bcd3..bcd0 thousands..units digit of the last committed result (registered)
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH = 10
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] bin,
   output logic             ready,
   output logic             done_tick,
   output logic [3:0]       bcd3,
   output logic [3:0]       bcd2,
   output logic [3:0]       bcd1,
   output logic [3:0]       bcd0
);

   localparam int CNT_W    = $clog2(WIDTH + 1);
   localparam int DIG_BITS = NUM_DIGITS * DIGIT_W;
   localparam int SHW      = DIG_BITS + WIDTH;

   // Wider inputs could exceed 9999 and there is no fifth digit to hold them.
   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("bin2bcd_seq: WIDTH must be within 1..13");
   end

   state_e              state_q, state_d;
   logic [WIDTH-1:0]    bin_q,   bin_d;
   logic [DIG_BITS-1:0] dig_q,   dig_d;
   logic [DIG_BITS-1:0] bcd_q,   bcd_d;
   logic [CNT_W-1:0]    cnt_q,   cnt_d;

   logic [DIG_BITS-1:0] dig_adj;
   logic [SHW-1:0]      shifted;

   // ------------------------------------------------------------------
   // Datapath: correct every working digit, then shift {digits, binary}
   // left by one so the binary MSB enters the units digit.
   // ------------------------------------------------------------------
   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (dig_q[g*DIGIT_W +: DIGIT_W]),
         .digit_out (dig_adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // Shifting the whole concatenation keeps WIDTH=1 legal (no empty slices).
   assign shifted = {dig_adj, bin_q} << 1;

   // ------------------------------------------------------------------
   // Next-state and output decode
   // ------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      bin_d     = bin_q;
      dig_d     = dig_q;
      cnt_d     = cnt_q;
      bcd_d     = bcd_q;
      ready     = 1'b0;
      done_tick = 1'b0;

      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (start) begin
               bin_d   = bin;
               dig_d   = '0;
               cnt_d   = CNT_W'(WIDTH);
               state_d = OP;
            end
         end

         OP: begin
            dig_d = shifted[SHW-1 -: DIG_BITS];
            bin_d = shifted[WIDTH-1:0];
            cnt_d = cnt_q - CNT_W'(1);
            // Last shift: commit the post-shift digits in the same edge so
            // the visible outputs jump straight from old result to new one.
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = shifted[SHW-1 -: DIG_BITS];
               state_d = DONE;
            end
         end

         DONE: begin
            done_tick = 1'b1;
            state_d   = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers; reset aborts any conversion in flight.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         bin_q   <= '0;
         dig_q   <= '0;
         cnt_q   <= '0;
         bcd_q   <= '0;
      end else begin
         state_q <= state_d;
         bin_q   <= bin_d;
         dig_q   <= dig_d;
         cnt_q   <= cnt_d;
         bcd_q   <= bcd_d;
      end
   end

   assign bcd3 = bcd_q[3*DIGIT_W +: DIGIT_W];
   assign bcd2 = bcd_q[2*DIGIT_W +: DIGIT_W];
   assign bcd1 = bcd_q[1*DIGIT_W +: DIGIT_W];
   assign bcd0 = bcd_q[0*DIGIT_W +: DIGIT_W];

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Purpose: self-checking bench for bin2bcd_seq with a queue of expected results.
// Latency: n/a.
// Backpressure: n/a.
module tb_bin2bcd_seq;

   localparam int WIDTH   = 10;
   localparam int TIMEOUT = 100;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] bin;
   logic             ready;
   logic             done_tick;
   logic [3:0]       bcd3, bcd2, bcd1, bcd0;

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_q[$];

   bin2bcd_seq #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bin       (bin),
      .ready     (ready),
      .done_tick (done_tick),
      .bcd3      (bcd3),
      .bcd2      (bcd2),
      .bcd1      (bcd1),
      .bcd0      (bcd0)
   );

   always #5 clk = ~clk;

   // Decimal reference by integer division.
   function automatic logic [15:0] model_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   function automatic logic [15:0] dut_bcd();
      return {bcd3, bcd2, bcd1, bcd0};
   endfunction

   function automatic logic [15:0] pop_exp();
      logic [15:0] e;
      e = 16'hxxxx;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      return e;
   endfunction

   // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
   task automatic launch(input logic [WIDTH-1:0] b);
      bin   = b;
      start = 1'b1;
      exp_q.push_back(model_bcd(int'(b)));
      @(negedge clk);
      start = 1'b0;
   endtask

   // lat = rising edges from the accept edge (inclusive) until done_tick is seen.
   task automatic wait_done(output int lat, output bit seen);
      seen = 1'b0;
      lat  = 1;
      for (int i = 0; i < TIMEOUT && !seen; i++) begin
         if (done_tick === 1'b1) seen = 1'b1;
         else begin
            @(negedge clk);
            lat++;
         end
      end
   endtask

   task automatic test_reset();
      #3;
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_in_reset: got %b want 1", ready); end
      total++; if (done_tick !== 1'b0) begin bad++; $display("FAIL reset_done_in_reset: got %b want 0", done_tick); end
      total++; if (dut_bcd() !== 16'h0000) begin bad++; $display("FAIL reset_bcd_in_reset: got %h want 0000", dut_bcd()); end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready_after: got %b want 1", ready); end
      total++; if (done_tick !== 1'b0) begin bad++; $display("FAIL reset_done_after: got %b want 0", done_tick); end
      total++; if (dut_bcd() !== 16'h0000) begin bad++; $display("FAIL reset_bcd_after: got %h want 0000", dut_bcd()); end
   endtask

   task automatic test_zero();
      int lat; bit seen; logic [15:0] e;
      launch(10'd0);
      wait_done(lat, seen);
      e = pop_exp();
      total++;
      if (!seen) begin bad++; $display("FAIL zero_timeout: got no done_tick want done within %0d", TIMEOUT); end
      else begin
         total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL zero_latency: got %0d want %0d", lat, WIDTH + 1); end
         total++; if (dut_bcd() !== e) begin bad++; $display("FAIL zero_result: got %h want %h", dut_bcd(), e); end
      end
      @(negedge clk);
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL zero_ready_after: got %b want 1", ready); end
   endtask

   task automatic test_max();
      int lat; bit seen; logic [15:0] e;
      launch(10'd1023);
      wait_done(lat, seen);
      e = pop_exp();
      total++;
      if (!seen) begin bad++; $display("FAIL max_timeout: got no done_tick want done within %0d", TIMEOUT); end
      else begin
         total++; if (lat !== WIDTH + 1) begin bad++; $display("FAIL max_latency: got %0d want %0d", lat, WIDTH + 1); end
         total++; if (dut_bcd() !== e) begin bad++; $display("FAIL max_result: got %h want %h", dut_bcd(), e); end
      end
      @(negedge clk);
      total++; if (done_tick !== 1'b0) begin bad++; $display("FAIL max_pulse_width: got %b want 0", done_tick); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL max_ready_after: got %b want 1", ready); end
   endtask

   task automatic test_boundaries();
      int lat; bit seen; logic [15:0] e; logic [15:0] first_res;
      int hold_bad; logic [15:0] hold_seen;
      launch(10'd59);
      wait_done(lat, seen);
      e = pop_exp();
      first_res = e;
      total++;
      if (!seen) begin bad++; $display("FAIL b59_timeout: got no done_tick want done within %0d", TIMEOUT); end
      else begin
         total++; if (dut_bcd() !== e) begin bad++; $display("FAIL b59_result: got %h want %h", dut_bcd(), e); end
      end
      @(negedge clk);
      launch(10'd999);
      hold_bad  = 0;
      hold_seen = first_res;
      seen      = 1'b0;
      for (int i = 0; i < TIMEOUT && !seen; i++) begin
         if (done_tick === 1'b1) seen = 1'b1;
         else begin
            if (dut_bcd() !== first_res) begin hold_bad++; hold_seen = dut_bcd(); end
            @(negedge clk);
         end
      end
      e = pop_exp();
      total++; if (hold_bad != 0) begin bad++; $display("FAIL b999_hold: got %h during conversion want %h", hold_seen, first_res); end
      total++;
      if (!seen) begin bad++; $display("FAIL b999_timeout: got no done_tick want done within %0d", TIMEOUT); end
      else begin
         total++; if (dut_bcd() !== e) begin bad++; $display("FAIL b999_result: got %h want %h", dut_bcd(), e); end
      end
      @(negedge clk);
   endtask

   task automatic test_ignore();
      int lat; bit seen; logic [15:0] e; int extra;
      launch(10'd300);
      @(negedge clk);
      @(negedge clk);
      bin   = 10'd512;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, seen);
      e = pop_exp();
      total++;
      if (!seen) begin bad++; $display("FAIL ignore_timeout: got no done_tick want done within %0d", TIMEOUT); end
      else begin
         total++; if (dut_bcd() !== e) begin bad++; $display("FAIL ignore_result: got %h want %h", dut_bcd(), e); end
      end
      extra = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done_tick === 1'b1) extra++;
      end
      total++; if (extra != 0) begin bad++; $display("FAIL ignore_no_second: got %0d extra done_tick want 0", extra); end
   endtask

   task automatic test_back_to_back();
      int last_done; int rdy_cnt; int done_cnt; logic [15:0] e;
      bin       = 10'd7;
      start     = 1'b1;
      exp_q.push_back(model_bcd(7));
      last_done = -1;
      rdy_cnt   = 0;
      done_cnt  = 0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         @(negedge clk);
         if (done_tick === 1'b1) begin
            done_cnt++;
            e = pop_exp();
            total++; if (dut_bcd() !== e) begin bad++; $display("FAIL b2b_result: got %h want %h at cycle %0d", dut_bcd(), e, cyc); end
            if (last_done >= 0) begin
               total++; if (cyc - last_done != WIDTH + 2) begin bad++; $display("FAIL b2b_interval: got %0d want %0d", cyc - last_done, WIDTH + 2); end
               total++; if (rdy_cnt != 1) begin bad++; $display("FAIL b2b_ready_cycles: got %0d want 1", rdy_cnt); end
            end
            last_done = cyc;
            rdy_cnt   = 0;
         end else if (ready === 1'b1) begin
            rdy_cnt++;
         end
         if (cyc == 60) start = 1'b0;
         if (ready === 1'b1 && start === 1'b1) exp_q.push_back(model_bcd(7));
      end
      total++; if (done_cnt != 60 / (WIDTH + 2)) begin bad++; $display("FAIL b2b_done_count: got %0d want %0d", done_cnt, 60 / (WIDTH + 2)); end
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_scoreboard_left: got %0d pending want 0", exp_q.size()); end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_op();
      int lat; bit seen; logic [15:0] e; int stray_done; int not_ready;
      launch(10'd1000);
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      total++; if (dut_bcd() !== 16'h0000) begin bad++; $display("FAIL midrst_bcd_async: got %h want 0000", dut_bcd()); end
      total++; if (ready !== 1'b1) begin bad++; $display("FAIL midrst_ready_async: got %b want 1", ready); end
      @(negedge clk);
      reset = 1'b0;
      stray_done = 0;
      not_ready  = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (done_tick === 1'b1) stray_done++;
         if (ready !== 1'b1) not_ready++;
      end
      total++; if (stray_done != 0) begin bad++; $display("FAIL midrst_no_done: got %0d done_tick want 0", stray_done); end
      total++; if (not_ready != 0) begin bad++; $display("FAIL midrst_ready_held: got %0d cycles not ready want 0", not_ready); end
      total++; if (dut_bcd() !== 16'h0000) begin bad++; $display("FAIL midrst_bcd_after: got %h want 0000", dut_bcd()); end
      launch(10'd1000);
      wait_done(lat, seen);
      e = pop_exp();
      total++;
      if (!seen) begin bad++; $display("FAIL midrst_rerun_timeout: got no done_tick want done within %0d", TIMEOUT); end
      else begin
         total++; if (dut_bcd() !== e) begin bad++; $display("FAIL midrst_rerun_result: got %h want %h", dut_bcd(), e); end
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      bin   = '0;
      test_reset();
      test_zero();
      test_max();
      test_boundaries();
      test_ignore();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_bin2bcd_seq
